// File: rtl/meteor_scheduler.sv
// Meteor-field game-state sequencer: one multi-cycle update pass per frame_tick that moves,
// retires and collision-checks every meteor slot, then spawns on a frame timer.
module meteor_scheduler #(
  parameter int          NUM_METEORS    = 6,
  parameter int          METEOR_SIZE    = 30,
  parameter int          SHIP_WIDTH     = 40,
  parameter int          SHIP_HEIGHT    = 15,
  parameter int          SCREEN_W       = 640,
  parameter int          SCREEN_H       = 480,
  parameter int          SPAWN_INTERVAL = 30,
  parameter int          BASE_SPEED     = 2,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   restart,
  input  logic [9:0]             ship_x,
  input  logic [8:0]             ship_y,
  output logic [9:0]             meteor_x [NUM_METEORS-1:0],
  output logic [8:0]             meteor_y [NUM_METEORS-1:0],
  output logic [NUM_METEORS-1:0] meteor_active,
  output logic [15:0]            score,
  output logic                   game_over,
  output logic                   busy
);

  localparam int IDX_W = (NUM_METEORS > 1) ? $clog2(NUM_METEORS) : 1;
  localparam int CNT_W = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_METEORS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SPAWN_INTERVAL - 1);
  localparam logic [10:0]      X_RANGE   = 11'(SCREEN_W - METEOR_SIZE);

  typedef enum logic [1:0] {IDLE, UPDATE, SPAWN} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] spawn_cnt;
  logic [15:0]      lfsr;

  logic [10:0]      new_y;
  logic             retire;
  logic             hit;
  logic             hit_now;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Speed ramps by one pixel/frame every 16 points, capped at +7.
  function automatic logic [10:0] speed_of(input logic [11:0] score_hi);
    return 11'(BASE_SPEED) + ((score_hi > 12'd7) ? 11'd7 : {8'd0, score_hi[2:0]});
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Fold the 10-bit random value into the legal spawn column range.
  function automatic logic [9:0] spawn_x(input logic [9:0] r);
    logic [10:0] w;
    w = {1'b0, r};
    return (w < X_RANGE) ? r : 10'(w - X_RANGE);
  endfunction

  always_comb begin
    new_y   = {2'b00, meteor_y[idx]} + speed_of(score[15:4]);
    retire  = (new_y >= 11'(SCREEN_H));
    hit     = ({1'b0, meteor_x[idx]} < {1'b0, ship_x} + 11'(SHIP_WIDTH)) &&
              ({1'b0, ship_x} < {1'b0, meteor_x[idx]} + 11'(METEOR_SIZE)) &&
              (new_y < {2'b00, ship_y} + 11'(SHIP_HEIGHT)) &&
              ({2'b00, ship_y} < new_y + 11'(METEOR_SIZE));
    hit_now = meteor_active[idx] && !retire && hit;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_METEORS - 1; i >= 0; i--) begin
      if (!meteor_active[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      busy          <= 1'b0;
      game_over     <= 1'b0;
      score         <= '0;
      spawn_cnt     <= '0;
      meteor_active <= '0;
      lfsr          <= LFSR_SEED;
      for (int i = 0; i < NUM_METEORS; i++) begin
        meteor_x[i] <= '0;
        meteor_y[i] <= '0;
      end
    end else if (restart) begin
      // Same clear as reset, but the LFSR keeps running so games differ.
      state         <= IDLE;
      idx           <= '0;
      busy          <= 1'b0;
      game_over     <= 1'b0;
      score         <= '0;
      spawn_cnt     <= '0;
      meteor_active <= '0;
      for (int i = 0; i < NUM_METEORS; i++) begin
        meteor_x[i] <= '0;
        meteor_y[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (frame_tick && !game_over) begin
            state <= UPDATE;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        UPDATE: begin
          if (meteor_active[idx]) begin
            if (retire) begin
              meteor_active[idx] <= 1'b0;
              score              <= sat_inc(score);
            end else begin
              meteor_y[idx] <= new_y[8:0];
            end
          end
          if (hit_now) begin
            game_over <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end else if (idx == LAST_IDX) begin
            state <= SPAWN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        SPAWN: begin
          lfsr <= lfsr_step(lfsr);
          if (spawn_cnt == LAST_CNT) begin
            spawn_cnt <= '0;
            if (free_found) begin
              meteor_active[free_idx] <= 1'b1;
              meteor_y[free_idx]      <= '0;
              meteor_x[free_idx]      <= spawn_x(lfsr[9:0]);
            end
          end else begin
            spawn_cnt <= spawn_cnt + 1'b1;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_meteor_scheduler.sv
// Self-checking bench for meteor_scheduler: frame-level reference model, table of
// milestone expectations, hand-written corner sequences and a randomized phase.
module tb_meteor_scheduler;

  localparam int N = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        restart;
  logic [9:0]  ship_x;
  logic [8:0]  ship_y;
  logic [9:0]  meteor_x [N-1:0];
  logic [8:0]  meteor_y [N-1:0];
  logic [N-1:0] meteor_active;
  logic [15:0] score;
  logic        game_over;
  logic        busy;

  meteor_scheduler dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .restart(restart),
    .ship_x(ship_x), .ship_y(ship_y), .meteor_x(meteor_x), .meteor_y(meteor_y),
    .meteor_active(meteor_active), .score(score), .game_over(game_over), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: whole-frame game rules on plain integers.
  int          mx [N];
  int          my [N];
  bit          ma [N];
  int          ms;
  bit          mgo;
  logic [15:0] mlfsr;
  int          mcnt;

  function automatic void model_restart();
    for (int i = 0; i < N; i++) begin mx[i] = 0; my[i] = 0; ma[i] = 0; end
    ms = 0; mgo = 0; mcnt = 0;
  endfunction

  function automatic void model_pass(input int sx, input int sy);
    int spd, ny, v;
    logic [15:0] old;
    if (mgo) return;
    spd = 2 + (((ms / 16) > 7) ? 7 : (ms / 16));
    for (int i = 0; i < N; i++) begin
      if (ma[i]) begin
        ny = my[i] + spd;
        if (ny >= 480) begin
          ma[i] = 0;
          ms = (ms >= 65535) ? 65535 : ms + 1;
          spd = 2 + (((ms / 16) > 7) ? 7 : (ms / 16));
        end else begin
          my[i] = ny;
          if (mx[i] < sx + 40 && sx < mx[i] + 30 && ny < sy + 15 && sy < ny + 30) begin
            mgo = 1;
            return;
          end
        end
      end
    end
    old = mlfsr;
    mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
    if (mcnt == 29) begin
      mcnt = 0;
      for (int i = 0; i < N; i++) begin
        if (!ma[i]) begin
          v = int'(old) % 1024;
          ma[i] = 1; my[i] = 0; mx[i] = (v < 610) ? v : v - 610;
          break;
        end
      end
    end else begin
      mcnt++;
    end
  endfunction

  task automatic chk(input string name, input int slot, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s slot=%0d actual=%0d expected=%0d", name, slot, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      chk({tag, "_active"}, i, meteor_active[i], ma[i]);
      chk({tag, "_x"}, i, meteor_x[i], mx[i]);
      chk({tag, "_y"}, i, meteor_y[i], my[i]);
    end
    chk({tag, "_score"}, -1, score, ms);
    chk({tag, "_game_over"}, -1, game_over, mgo);
    chk({tag, "_busy"}, -1, busy, 0);
  endtask

  task automatic run_frame(input int gap);
    repeat (gap) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (7) @(negedge clk);
    model_pass(int'(ship_x), int'(ship_y));
    check_all("frame");
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    model_restart();
    check_all("restart");
  endtask

  typedef struct {
    int          frames;
    logic [N-1:0] act;
    int          y0;
    int          sc;
  } vec_t;

  int fc;
  int bc;
  int prev_y;
  int slot;

  initial begin
    #950000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    tbl = '{
      '{30,  6'b000001, 0,   0},
      '{31,  6'b000001, 2,   0},
      '{60,  6'b000011, 60,  0},
      '{180, 6'b111111, 300, 0},
      '{240, 6'b111111, 420, 0},
      '{269, 6'b111111, 478, 0},
      '{270, 6'b111111, 0,   1},
      '{271, 6'b111111, 2,   1}
    };
    reset = 1'b1; frame_tick = 1'b0; restart = 1'b0;
    ship_x = 10'd1000; ship_y = 9'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_restart();
    mlfsr = 16'hACE1;
    check_all("reset");

    // Milestones with the ship out of reach of every column.
    fc = 0;
    for (int r = 0; r < 8; r++) begin
      while (fc < tbl[r].frames) begin run_frame(0); fc++; end
      chk("tbl_active", r, meteor_active, tbl[r].act);
      chk("tbl_y0", r, meteor_y[0], tbl[r].y0);
      chk("tbl_score", r, score, tbl[r].sc);
      if (r == 0) chk("spawn_x_range", 0, (meteor_x[0] < 10'd610), 1);
    end

    // Keep dodging until speed reaches its cap.
    while (ms < 115 && fc < 6000) begin
      ship_x = 10'($urandom_range(640, 1023));
      ship_y = 9'($urandom_range(0, 511));
      run_frame($urandom_range(0, 2));
      fc++;
    end
    chk("score_reached", -1, (score >= 16'd115), 1);
    slot = -1;
    for (int k = 0; k < 40 && slot < 0; k++) begin
      for (int i = 0; i < N; i++)
        if (slot < 0 && ma[i] && my[i] + 9 < 480) slot = i;
      if (slot < 0) run_frame(0);
    end
    chk("cap_slot_found", -1, (slot >= 0), 1);
    if (slot >= 0) begin
      prev_y = int'(meteor_y[slot]);
      run_frame(0);
      chk("speed_cap", slot, int'(meteor_y[slot]) - prev_y, 9);
    end

    // Second tick 3 cycles into a pass is dropped; busy lasts 7 cycles.
    frame_tick = 1'b1;
    @(negedge clk);
    bc = 0;
    for (int c = 0; c < 12; c++) begin
      if (busy) bc++;
      frame_tick = (c == 2);
      @(negedge clk);
    end
    frame_tick = 1'b0;
    model_pass(int'(ship_x), int'(ship_y));
    chk("busy_cycles", -1, bc, 7);
    check_all("double_tick");

    // Restart during the second UPDATE cycle.
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    pulse_restart();
    chk("rst_mid_active", -1, meteor_active, 0);

    // Collision: ship parked under meteor 0.
    ship_x = 10'd1000; ship_y = 9'd0;
    for (int f = 0; f < 30; f++) run_frame(0);
    ship_x = 10'(mx[0]); ship_y = 9'd440;
    for (int f = 0; f < 205; f++) run_frame(0);
    chk("pre_hit_go", -1, game_over, 0);
    chk("pre_hit_y0", 0, meteor_y[0], 410);
    run_frame(0);
    chk("hit_go", -1, game_over, 1);
    chk("hit_y0", 0, meteor_y[0], 412);
    chk("hit_active0", 0, meteor_active[0], 1);
    for (int f = 0; f < 3; f++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      bc = 0;
      for (int c = 0; c < 8; c++) begin
        if (busy) bc++;
        @(negedge clk);
      end
      chk("go_busy", f, bc, 0);
      check_all("go_frozen");
    end
    pulse_restart();

    // Randomized play with occasional restarts.
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if ((mgo && r < 30) || r == 0) begin
        pulse_restart();
      end else begin
        if (r < 40) begin
          ship_x = 10'($urandom_range(0, 639));
          ship_y = 9'($urandom_range(0, 479));
        end else begin
          ship_x = 10'($urandom_range(640, 1023));
          ship_y = 9'($urandom_range(0, 511));
        end
        run_frame($urandom_range(0, 3));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
